text_dma_sched: RTL and testbench
=================================

Name: text_dma_sched

Overview:
- Per-line scheduler for the text sprite renderer.
- Selects the active greeting message on a frame-based timer.
- On each DMA request in horizontal blanking, sequences greeting-ROM reads, captures one code point per sprite, then shares the single font ROM between SPR_CNT sprites by issuing one glyph-line address per sprite with a one-hot DMA grant.
- Sits between the greeting/font rom_sync instances and the sprite array.

Parameters:
- SPR_CNT, 8, number of sprites (characters per row).
- GREET_MSGS, 32, number of messages in greeting ROM.
- GREET_LENGTH, 16, code points per message (two rows of GREET_LENGTH/2).
- CP_W, 7, code point width.
- FONT_HEIGHT, 8, glyph lines per glyph.
- NUM_GLYPHS, 64, glyphs in font ROM.
- CP_START, 'h20, first code point in font ROM.
- TXT_PAUSE, 80, frames per message.

Ports:
- video_clk_pix  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse per frame.
- msg_hold  in  1  freeze message timer while high.
- dma_start  in  1  one-cycle request to fetch the current line.
- row_sel  in  1  0 = first half of message, 1 = second half; sampled with dma_start.
- glyph_line  in  SPR_CNT*$clog2(FONT_HEIGHT)  per-sprite current glyph line (sprite k at slice k).
- greet_addr  out  $clog2(GREET_MSGS*GREET_LENGTH)  greeting ROM address.
- greet_data  in  CP_W  greeting ROM data, valid one cycle after address.
- font_addr  out  $clog2(NUM_GLYPHS*FONT_HEIGHT)  font ROM address.
- spr_fdma  out  SPR_CNT  one-hot font DMA grant.
- greeting  out  $clog2(GREET_MSGS)  current message index.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- Reset: clock video_clk_pix; reset rst_n asynchronous, active-low. Reset values:
  - greet_addr, font_addr, spr_fdma, busy, done, greeting = 0.
  - Frame counter 0, all captured code points 0, FSM IDLE.
- All outputs are registered.
- Message timer:
  - On frame_start with msg_hold=0, the frame counter increments.
  - When the counter equals TXT_PAUSE-1 it wraps to 0 and greeting increments modulo GREET_MSGS, so the message changes exactly every TXT_PAUSE frames.
  - msg_hold=1 freezes both counter and greeting.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on dma_start. Latch base = greeting*GREET_LENGTH + row_sel*(GREET_LENGTH/2) and clear slot counter c.
  - dma_start outside IDLE is ignored (no queueing).
- RUN timing (cycle n = n-th cycle after the dma_start edge; busy=1 for n=1..SPR_CNT+2):
  - Cycles n=1..SPR_CNT: greet_addr = base+n-1. In all other cycles greet_addr holds its last value.
  - Code point for sprite k is captured from greet_data in cycle k+2.
  - Cycle k+3 (k=0..SPR_CNT-1): spr_fdma = 1<<k and font_addr = glyph(cp[k])*FONT_HEIGHT + glyph_line[k], with glyph_line[k] sampled that cycle.
  - spr_fdma = 0 outside these cycles; font_addr holds its last value.
  - glyph(cp) = cp-CP_START if CP_START <= cp < CP_START+NUM_GLYPHS, else 0 (space). Arithmetic is unsigned, width-extended to the address width before the multiply.
- RUN -> DONE after cycle SPR_CNT+2. DONE asserts done=1 and busy=0 for one cycle, then -> IDLE.
- Latency: dma_start to done = SPR_CNT+3 cycles (11 at defaults).
- Simultaneous frame_start and dma_start: base uses the pre-update greeting; the new message applies from the next dma_start.
- Mid-sequence greeting change: no effect on the running sequence (base is latched).
- rst_n low mid-sequence: immediate return to IDLE, all outputs 0, no done pulse.

Decomposition:
- Package text_pkg holds:
  - Constants CP_START, FONT_HEIGHT, NUM_GLYPHS, GREET_LENGTH, GREET_MSGS.
  - Typedefs cp_t (CP_W bits), greet_addr_t, font_addr_t.
  - Enum sched_state_t {IDLE, RUN, DONE}.
- One sub-module: greet_selector, containing the frame counter, msg_hold and greeting output.
- The slot pipeline and FSM stay in text_dma_sched.

Test Plan:
- Reset then 80 frame_start pulses -> greeting 0 through pulse 79, 1 after pulse 80. After 32*80 pulses -> greeting wraps to 0.
- greeting=3, row_sel=1, dma_start -> greet_addr 56..63 in cycles 1..8; busy high cycles 1..10; done in cycle 11.
- Greeting ROM returns 'h41 for sprite 2, glyph_line[2]=5 -> cycle 5: spr_fdma=8'b00000100, font_addr=(0x21*8)+5=269.
- Code points 'h1F and 'h60 -> font_addr = glyph_line (glyph 0).
- dma_start re-pulsed in cycle 4 -> ignored, single done. rst_n low in cycle 6 -> outputs 0 immediately, no done; next dma_start runs a full sequence.
- frame_start coincident with rollover and dma_start -> sequence addresses use the old message; the next line uses the new one. msg_hold=1 across 200 frames -> greeting unchanged.

Source files
------------

// File: rtl/text_dma_sched_pkg.sv
// Shared constants, types and helpers for the text sprite DMA scheduler.
package text_pkg;

   localparam int CP_W         = 7;
   localparam int CP_START     = 'h20;
   localparam int FONT_HEIGHT  = 8;
   localparam int NUM_GLYPHS   = 64;
   localparam int GREET_LENGTH = 16;
   localparam int GREET_MSGS   = 32;

   localparam int GL_W         = $clog2(FONT_HEIGHT);
   localparam int GREET_ADDR_W = $clog2(GREET_MSGS * GREET_LENGTH);
   localparam int FONT_ADDR_W  = $clog2(NUM_GLYPHS * FONT_HEIGHT);
   localparam int MSG_W        = $clog2(GREET_MSGS);

   typedef logic [CP_W-1:0]         cp_t;
   typedef logic [GREET_ADDR_W-1:0] greet_addr_t;
   typedef logic [FONT_ADDR_W-1:0]  font_addr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   // Code points outside the font fall back to glyph 0 (space).
   function automatic font_addr_t glyph_idx(input cp_t cp);
      font_addr_t ext;
      ext = font_addr_t'(cp);
      if (ext >= font_addr_t'(CP_START) && ext < font_addr_t'(CP_START + NUM_GLYPHS))
         return ext - font_addr_t'(CP_START);
      return '0;
   endfunction

endpackage

// File: rtl/text_dma_sched_greet_selector.sv
// Frame-based message timer: advances the greeting index every TXT_PAUSE frames.
module greet_selector
   import text_pkg::*;
#(
   parameter int TXT_PAUSE = 80
) (
   input  logic             video_clk_pix,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             msg_hold,
   output logic [MSG_W-1:0] greeting
);
   localparam int FC_W = (TXT_PAUSE > 1) ? $clog2(TXT_PAUSE) : 1;
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(TXT_PAUSE - 1);
   localparam logic [MSG_W-1:0] MSG_LAST = MSG_W'(GREET_MSGS - 1);

   logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [MSG_W-1:0] greeting_q, greeting_d;

   // Count unheld frames; on the last frame of a message wrap and step to the next message.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      greeting_d  = greeting_q;
      if (frame_start && !msg_hold) begin
         if (frame_cnt_q == FC_LAST) begin
            frame_cnt_d = '0;
            greeting_d  = (greeting_q == MSG_LAST) ? '0 : greeting_q + 1'b1;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   // Timer state registers.
   always_ff @(posedge video_clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         greeting_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         greeting_q  <= greeting_d;
      end
   end

   assign greeting = greeting_q;

endmodule

// File: rtl/text_dma_sched.sv
// Per-line text sprite scheduler: fetches one row of code points from the
// greeting ROM and hands out font ROM glyph-line reads one sprite at a time.
//
//   state | meaning
//   IDLE  | waiting for dma_start
//   RUN   | greeting reads, code point capture, font grants
//   DONE  | one-cycle done pulse, back to IDLE
module text_dma_sched
   import text_pkg::*;
#(
   parameter int SPR_CNT   = 8,
   parameter int TXT_PAUSE = 80
) (
   input  logic                    video_clk_pix,
   input  logic                    rst_n,
   input  logic                    frame_start,
   input  logic                    msg_hold,
   input  logic                    dma_start,
   input  logic                    row_sel,
   input  logic [SPR_CNT*GL_W-1:0] glyph_line,
   output logic [GREET_ADDR_W-1:0] greet_addr,
   input  logic [CP_W-1:0]         greet_data,
   output logic [FONT_ADDR_W-1:0]  font_addr,
   output logic [SPR_CNT-1:0]      spr_fdma,
   output logic [MSG_W-1:0]        greeting,
   output logic                    busy,
   output logic                    done
);
   localparam int CNT_W  = $clog2(SPR_CNT + 3);
   localparam int SLOT_W = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_FETCHES   = CNT_W'(SPR_CNT);
   localparam logic [CNT_W-1:0] CNT_FIRST_CAP = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_LAST_CAP  = CNT_W'(SPR_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_END       = CNT_W'(SPR_CNT + 2);

   sched_state_t       state_q, state_d;
   greet_addr_t        base_q, base_d;
   greet_addr_t        greet_addr_q, greet_addr_d;
   font_addr_t         font_addr_q, font_addr_d;
   logic [SPR_CNT-1:0] spr_fdma_q, spr_fdma_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   cp_t                cp_q [SPR_CNT];
   cp_t                cp_d [SPR_CNT];
   logic [SLOT_W-1:0]  slot;
   logic [GL_W-1:0]    slot_line;

   greet_selector #(
      .TXT_PAUSE (TXT_PAUSE)
   ) u_greet_sel (
      .video_clk_pix (video_clk_pix),
      .rst_n         (rst_n),
      .frame_start   (frame_start),
      .msg_hold      (msg_hold),
      .greeting      (greeting)
   );

   // cnt_q holds the cycle number n inside RUN; ROM data for sprite k shows up at n = k+2.
   assign slot      = SLOT_W'(cnt_q - CNT_FIRST_CAP);
   assign slot_line = glyph_line[slot*GL_W +: GL_W];

   // Next-state and next-output logic for the fetch sequence.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      greet_addr_d = greet_addr_q;
      font_addr_d  = font_addr_q;
      spr_fdma_d   = '0;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      cp_d         = cp_q;
      unique case (state_q)
         IDLE: begin
            if (dma_start) begin
               base_d = greet_addr_t'(greeting) * greet_addr_t'(GREET_LENGTH)
                      + (row_sel ? greet_addr_t'(GREET_LENGTH / 2) : '0);
               greet_addr_d = base_d;
               cnt_d        = CNT_W'(1);
               busy_d       = 1'b1;
               state_d      = RUN;
            end
         end
         RUN: begin
            if (cnt_q < CNT_FETCHES)
               greet_addr_d = base_q + greet_addr_t'(cnt_q);
            if (cnt_q >= CNT_FIRST_CAP && cnt_q <= CNT_LAST_CAP) begin
               cp_d[slot]  = greet_data;
               spr_fdma_d  = SPR_CNT'(1) << slot;
               font_addr_d = glyph_idx(greet_data) * font_addr_t'(FONT_HEIGHT)
                           + font_addr_t'(slot_line);
            end
            if (cnt_q == CNT_END) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Sequencer registers; every output comes straight from a flop.
   always_ff @(posedge video_clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         base_q       <= '0;
         greet_addr_q <= '0;
         font_addr_q  <= '0;
         spr_fdma_q   <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cp_q         <= '{default: '0};
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         greet_addr_q <= greet_addr_d;
         font_addr_q  <= font_addr_d;
         spr_fdma_q   <= spr_fdma_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cp_q         <= cp_d;
      end
   end

   assign greet_addr = greet_addr_q;
   assign font_addr  = font_addr_q;
   assign spr_fdma   = spr_fdma_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_text_dma_sched.sv
// Bench for text_dma_sched: synchronous greeting ROM model plus a frame-count
// based message model and per-cycle expectations derived from the schedule.
module tb_text_dma_sched;
   import text_pkg::*;

   localparam int SPR   = 8;
   localparam int PAUSE = 80;

   logic                    video_clk_pix = 1'b0;
   logic                    rst_n         = 1'b0;
   logic                    frame_start   = 1'b0;
   logic                    msg_hold      = 1'b0;
   logic                    dma_start     = 1'b0;
   logic                    row_sel       = 1'b0;
   logic [SPR*GL_W-1:0]     glyph_line    = '0;
   logic [GREET_ADDR_W-1:0] greet_addr;
   logic [CP_W-1:0]         greet_data;
   logic [FONT_ADDR_W-1:0]  font_addr;
   logic [SPR-1:0]          spr_fdma;
   logic [MSG_W-1:0]        greeting;
   logic                    busy;
   logic                    done;

   int total = 0;
   int bad   = 0;
   int frames_counted = 0;
   int font_model = 0;
   int greet_rom [GREET_MSGS*GREET_LENGTH];
   int line_v [SPR];

   text_dma_sched #(
      .SPR_CNT   (SPR),
      .TXT_PAUSE (PAUSE)
   ) dut (
      .video_clk_pix (video_clk_pix),
      .rst_n         (rst_n),
      .frame_start   (frame_start),
      .msg_hold      (msg_hold),
      .dma_start     (dma_start),
      .row_sel       (row_sel),
      .glyph_line    (glyph_line),
      .greet_addr    (greet_addr),
      .greet_data    (greet_data),
      .font_addr     (font_addr),
      .spr_fdma      (spr_fdma),
      .greeting      (greeting),
      .busy          (busy),
      .done          (done)
   );

   always #5 video_clk_pix = ~video_clk_pix;

   always @(posedge video_clk_pix) greet_data <= CP_W'(greet_rom[greet_addr]);

   function automatic int exp_greet();
      return (frames_counted / PAUSE) % GREET_MSGS;
   endfunction

   function automatic int glyph(input int cp);
      if (cp >= CP_START && cp < CP_START + NUM_GLYPHS) return cp - CP_START;
      return 0;
   endfunction

   task automatic randomize_lines();
      for (int k = 0; k < SPR; k++) line_v[k] = $urandom_range(0, FONT_HEIGHT - 1);
   endtask

   task automatic apply_lines();
      for (int k = 0; k < SPR; k++) glyph_line[k*GL_W +: GL_W] = GL_W'(line_v[k]);
   endtask

   task automatic pulse_frames(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         @(negedge video_clk_pix);
         frame_start = 1'b1;
         @(negedge video_clk_pix);
         frame_start = 1'b0;
         if (!msg_hold) frames_counted++;
         total++;
         if (greeting !== MSG_W'(exp_greet())) begin
            bad++;
            $display("FAIL greeting frames=%0d hold=%0b: got %0d want %0d",
                     frames_counted, msg_hold, greeting, exp_greet());
         end
      end
   endtask

   // One full line fetch; cycle n is the n-th negedge after the edge sampling dma_start.
   task automatic run_seq(input int row, input int retrig, input bit coinc);
      int base, ea, efd;
      bit eb, ed;
      base = exp_greet() * GREET_LENGTH + row * (GREET_LENGTH / 2);
      apply_lines();
      @(negedge video_clk_pix);
      row_sel     = row[0];
      dma_start   = 1'b1;
      frame_start = coinc;
      for (int n = 1; n <= SPR + 6; n++) begin
         @(negedge video_clk_pix);
         if (n == 1) begin
            frame_start = 1'b0;
            if (coinc) frames_counted++;
         end
         ea = base + ((n < SPR) ? n : SPR) - 1;
         eb = (n <= SPR + 2);
         ed = (n == SPR + 3);
         efd = 0;
         if (n >= 3 && n <= SPR + 2) begin
            efd = 1 << (n - 3);
            font_model = glyph(greet_rom[base + n - 3]) * FONT_HEIGHT + line_v[n - 3];
         end
         total++;
         if (greet_addr !== GREET_ADDR_W'(ea)) begin
            bad++;
            $display("FAIL seq greet_addr cyc%0d: got %0d want %0d", n, greet_addr, ea);
         end
         total++;
         if (busy !== eb) begin
            bad++;
            $display("FAIL seq busy cyc%0d: got %0b want %0b", n, busy, eb);
         end
         total++;
         if (done !== ed) begin
            bad++;
            $display("FAIL seq done cyc%0d: got %0b want %0b", n, done, ed);
         end
         total++;
         if (spr_fdma !== SPR'(efd)) begin
            bad++;
            $display("FAIL seq spr_fdma cyc%0d: got %b want %b", n, spr_fdma, SPR'(efd));
         end
         total++;
         if (font_addr !== FONT_ADDR_W'(font_model)) begin
            bad++;
            $display("FAIL seq font_addr cyc%0d: got %0d want %0d", n, font_addr, font_model);
         end
         dma_start = (n == retrig);
      end
      dma_start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (greet_addr !== '0 || font_addr !== '0 || spr_fdma !== '0 ||
          greeting !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset outputs: got ga=%0d fa=%0d fdma=%b g=%0d busy=%b done=%b want all 0",
                  greet_addr, font_addr, spr_fdma, greeting, busy, done);
      end
      @(negedge video_clk_pix);
      rst_n = 1'b1;
   endtask

   task automatic test_timer();
      pulse_frames(PAUSE * GREET_MSGS);
   endtask

   task automatic test_known_row();
      pulse_frames(3 * PAUSE);
      greet_rom[58] = 'h41;
      greet_rom[59] = 'h1F;
      greet_rom[60] = 'h60;
      randomize_lines();
      line_v[2] = 5;
      run_seq(1, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         randomize_lines();
         if ($urandom_range(0, 1) == 1) pulse_frames($urandom_range(1, 100));
         run_seq($urandom_range(0, 1), 0, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      randomize_lines();
      run_seq(0, 0, 1'b0);
      run_seq(1, 0, 1'b0);
   endtask

   task automatic test_retrigger();
      randomize_lines();
      run_seq($urandom_range(0, 1), 4, 1'b0);
   endtask

   task automatic test_coincident();
      pulse_frames((PAUSE - 1 - (frames_counted % PAUSE) + PAUSE) % PAUSE);
      randomize_lines();
      run_seq(0, 0, 1'b1);
      total++;
      if (greeting !== MSG_W'(exp_greet())) begin
         bad++;
         $display("FAIL coincident greeting: got %0d want %0d", greeting, exp_greet());
      end
      randomize_lines();
      run_seq(1, 0, 1'b0);
   endtask

   task automatic test_hold();
      msg_hold = 1'b1;
      pulse_frames(200);
      msg_hold = 1'b0;
      pulse_frames(90);
   endtask

   task automatic test_reset_mid();
      randomize_lines();
      apply_lines();
      @(negedge video_clk_pix);
      row_sel   = 1'b0;
      dma_start = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge video_clk_pix);
         dma_start = 1'b0;
      end
      total++;
      if (spr_fdma !== SPR'(8)) begin
         bad++;
         $display("FAIL reset_mid pre grant: got %b want %b", spr_fdma, SPR'(8));
      end
      rst_n = 1'b0;
      #1;
      frames_counted = 0;
      font_model     = 0;
      total++;
      if (greet_addr !== '0 || font_addr !== '0 || spr_fdma !== '0 ||
          greeting !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid outputs: got ga=%0d fa=%0d fdma=%b g=%0d busy=%b done=%b want all 0",
                  greet_addr, font_addr, spr_fdma, greeting, busy, done);
      end
      @(negedge video_clk_pix);
      rst_n = 1'b1;
      for (int i = 0; i < SPR + 6; i++) begin
         @(negedge video_clk_pix);
         total++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid quiet cyc%0d: got busy=%b done=%b want 0 0", i, busy, done);
         end
      end
      randomize_lines();
      run_seq($urandom_range(0, 1), 0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < GREET_MSGS * GREET_LENGTH; i++) greet_rom[i] = $urandom_range(0, 127);
      for (int k = 0; k < SPR; k++) line_v[k] = 0;
      test_reset();
      test_timer();
      test_known_row();
      test_random();
      test_back_to_back();
      test_retrigger();
      test_coincident();
      test_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
